// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default data width, register index width,
// writeback FSM states and the default writeback queue entry layout.
package cpu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned REG_AW       = 5;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } wb_state_e;

  typedef struct packed {
    logic [REG_AW-1:0]       rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback queue: power-of-two circular buffer that exposes its storage, read
// pointer and occupancy so the owner can scan pending entries in age order.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  entry_t                   i_data,
  input  logic                     i_pop,
  output entry_t                   o_head,
  output entry_t                   o_mem [DEPTH],
  output logic [$clog2(DEPTH)-1:0] o_rptr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_mem   = r_mem;
  assign o_rptr  = r_rptr;
  assign o_count = r_count;

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: queues execute results and drains them to the register file
// through an IDLE/ISSUE/WAIT handshake. Define WB_FORWARD_EN to add forwarding ports.
module writeback_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = XLEN_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [REG_AW-1:0]      res_rd,
  input  logic [XLEN-1:0]        res_data,
  output logic                   we,
  output logic [REG_AW-1:0]      wa,
  output logic [XLEN-1:0]        wd,
  input  logic                   wr,
  input  logic [REG_AW-1:0]      ra1,
  input  logic [REG_AW-1:0]      ra2,
  output logic                   hazard1,
  output logic                   hazard2,
`ifdef WB_FORWARD_EN
  output logic                   fwd1_valid,
  output logic                   fwd2_valid,
  output logic [XLEN-1:0]        fwd1_data,
  output logic [XLEN-1:0]        fwd2_data,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_ent_t;

  wb_state_e        r_state;
  wb_state_e        w_state_next;
  logic [REG_AW-1:0] r_wa;
  logic [XLEN-1:0]  r_wd;
  logic             w_pop;
  wb_ent_t          w_head;
  wb_ent_t          w_mem [DEPTH];
  wb_ent_t          w_in;
  logic [AW-1:0]    w_rptr;
  logic [AW-1:0]    w_idx;
  logic [AW:0]      w_count;
  logic             w_hit1;
  logic             w_hit2;
`ifdef WB_FORWARD_EN
  logic [XLEN-1:0]  w_fdat1;
  logic [XLEN-1:0]  w_fdat2;
`endif

  assign w_in = '{rd: res_rd, data: res_data};

  // x0 results complete the handshake but are never queued.
  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_ent_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (res_valid && (res_rd != '0)),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_mem   (w_mem),
    .o_rptr  (w_rptr),
    .o_count (w_count),
    .o_full  (full),
    .o_empty (empty)
  );

  assign res_ready = !full;
  assign count     = w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (!empty && wr) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (wr) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    we    = (r_state == StIssue);
    w_pop = (r_state == StIssue);
  end

  // Address/data are captured on entry to ISSUE and held afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wa <= '0;
      r_wd <= '0;
    end else if (r_state == StIdle && w_state_next == StIssue) begin
      r_wa <= w_head.rd;
      r_wd <= w_head.data;
    end
  end

  assign wa = r_wa;
  assign wd = r_wd;

  // Scan oldest to youngest so the last match is the youngest pending write.
  always_comb begin
    w_hit1 = we && (wa == ra1);
    w_hit2 = we && (wa == ra2);
    w_idx  = '0;
`ifdef WB_FORWARD_EN
    w_fdat1 = wd;
    w_fdat2 = wd;
`endif
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_idx = w_rptr + AW'(i);
      if (i < int'(w_count)) begin
        if (w_mem[w_idx].rd == ra1) begin
          w_hit1 = 1'b1;
`ifdef WB_FORWARD_EN
          w_fdat1 = w_mem[w_idx].data;
`endif
        end
        if (w_mem[w_idx].rd == ra2) begin
          w_hit2 = 1'b1;
`ifdef WB_FORWARD_EN
          w_fdat2 = w_mem[w_idx].data;
`endif
        end
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign hazard1    = 1'b0;
  assign hazard2    = 1'b0;
  assign fwd1_valid = w_hit1 && (ra1 != '0);
  assign fwd2_valid = w_hit2 && (ra2 != '0);
  assign fwd1_data  = w_fdat1;
  assign fwd2_data  = w_fdat2;
`else
  assign hazard1 = w_hit1 && (ra1 != '0);
  assign hazard2 = w_hit2 && (ra2 != '0);
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_writeback_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [4:0]    res_rd = '0;
  logic [31:0]   res_data = '0;
  logic          we;
  logic [4:0]    wa;
  logic [31:0]   wd;
  logic          wr;
  logic [4:0]    ra1 = '0;
  logic [4:0]    ra2 = '0;
  logic          hazard1, hazard2;
  logic [CW-1:0] count;
  logic          full, empty;
`ifdef WB_FORWARD_EN
  logic          fwd1_valid, fwd2_valid;
  logic [31:0]   fwd1_data, fwd2_data;
`endif

  int checks = 0;
  int errors = 0;

  logic wr_en = 1'b0;
  logic wr_blk;

  writeback_unit #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_rd     (res_rd),
    .res_data   (res_data),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .wr         (wr),
    .ra1        (ra1),
    .ra2        (ra2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
`ifdef WB_FORWARD_EN
    .fwd1_valid (fwd1_valid),
    .fwd2_valid (fwd2_valid),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
`endif
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Register file model: not ready for the cycle after each write.
  always @(posedge clk or posedge reset) begin
    if (reset) wr_blk <= 1'b0;
    else       wr_blk <= we;
  end
  assign wr = wr_en & ~wr_blk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of pending writes in arrival order.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [4:0]  wlog[$];
  bit          m_h1, m_h2, m_push;
  logic [31:0] m_f1, m_f2;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      prev_we = 1'b0;
      chk("m_rst_we", 64'(we), 64'(0));
      chk("m_rst_count", 64'(count), 64'(0));
    end else begin
      m_h1 = 1'b0; m_h2 = 1'b0; m_f1 = '0; m_f2 = '0;
      foreach (q[i]) begin
        if (ra1 != 0 && q[i].rd == ra1) begin m_h1 = 1'b1; m_f1 = q[i].data; end
        if (ra2 != 0 && q[i].rd == ra2) begin m_h2 = 1'b1; m_f2 = q[i].data; end
      end
      chk("m_count", 64'(count), 64'(q.size()));
      chk("m_full", 64'(full), 64'(q.size() == DEPTH));
      chk("m_empty", 64'(empty), 64'(q.size() == 0));
      chk("m_res_ready", 64'(res_ready), 64'(q.size() != DEPTH));
`ifdef WB_FORWARD_EN
      chk("m_hazard1", 64'(hazard1), 64'(0));
      chk("m_hazard2", 64'(hazard2), 64'(0));
      chk("m_fwd1_valid", 64'(fwd1_valid), 64'(m_h1));
      chk("m_fwd2_valid", 64'(fwd2_valid), 64'(m_h2));
      if (m_h1) chk("m_fwd1_data", 64'(fwd1_data), 64'(m_f1));
      if (m_h2) chk("m_fwd2_data", 64'(fwd2_data), 64'(m_f2));
`else
      chk("m_hazard1", 64'(hazard1), 64'(m_h1));
      chk("m_hazard2", 64'(hazard2), 64'(m_h2));
`endif
      chk("m_we_single", 64'(we && prev_we), 64'(0));
      m_push = res_valid && (res_rd != 0) && (q.size() < DEPTH);
      if (we) begin
        if (q.size() == 0) begin
          chk("m_we_when_empty", 64'(we), 64'(0));
        end else begin
          chk("m_wa", 64'(wa), 64'(q[0].rd));
          chk("m_wd", 64'(wd), 64'(q[0].data));
          wlog.push_back(wa);
          void'(q.pop_front());
        end
      end
      if (m_push) q.push_back('{rd: res_rd, data: res_data});
      prev_we = we;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    int n;
    res_valid = 1'b1; res_rd = rd; res_data = d; n = 0;
    @(negedge clk);
    while (!res_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!res_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: res_ready stayed 0, expected 1 within 50 cycles");
    end
    step();
    res_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clk);
    while (!(empty && !we) && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!(empty && !we)) begin
      errors++;
      $display("FAIL drain_timeout: empty=%0b, expected 1 within 100 cycles", empty);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_wa", 64'(wa), 64'(0));
    chk("rst_wd", 64'(wd), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_res_ready", 64'(res_ready), 64'(1));
    chk("rst_hazard1", 64'(hazard1), 64'(0));
    reset = 1'b0;

    // Single write latency: accepted in N, we high in N+2 for one cycle.
    wr_en = 1'b1; ra1 = 5'd5; ra2 = 5'd9;
    push(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_n1_we", 64'(we), 64'(0));
`ifndef WB_FORWARD_EN
    chk("lat_pending_hazard1", 64'(hazard1), 64'(1));
`endif
    @(negedge clk);
    chk("lat_n2_we", 64'(we), 64'(1));
    chk("lat_n2_wa", 64'(wa), 64'(5));
    chk("lat_n2_wd", 64'(wd), 64'hDEADBEEF);
    @(negedge clk);
    chk("lat_n3_we", 64'(we), 64'(0));
    chk("lat_n3_wa_hold", 64'(wa), 64'(5));
    step();

    // x0 result: handshake completes, nothing queued or written.
    push(5'd0, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("x0_count", 64'(count), 64'(0));
      chk("x0_res_ready", 64'(res_ready), 64'(1));
      chk("x0_we", 64'(we), 64'(0));
    end
    step();

    // Pending rd=7 hazard, then youngest-of-two forwarding for rd=3.
    wr_en = 1'b0;
    push(5'd7, 32'hCAFE0007);
    ra1 = 5'd7; ra2 = 5'd0;
    @(negedge clk);
`ifdef WB_FORWARD_EN
    chk("h7_fwd1_valid", 64'(fwd1_valid), 64'(1));
    chk("h7_fwd1_data", 64'(fwd1_data), 64'hCAFE0007);
    chk("h7_fwd2_valid", 64'(fwd2_valid), 64'(0));
`else
    chk("h7_hazard1", 64'(hazard1), 64'(1));
`endif
    chk("h7_hazard2", 64'(hazard2), 64'(0));
    step();
    push(5'd3, 32'h11);
    push(5'd3, 32'h22);
    ra1 = 5'd3; ra2 = 5'd7;
    @(negedge clk);
    chk("y3_count", 64'(count), 64'(3));
`ifdef WB_FORWARD_EN
    chk("y3_fwd1_data", 64'(fwd1_data), 64'h22);
    chk("y3_fwd2_data", 64'(fwd2_data), 64'hCAFE0007);
`else
    chk("y3_hazard1", 64'(hazard1), 64'(1));
    chk("y3_hazard2", 64'(hazard2), 64'(1));
`endif
    step();
    wr_en = 1'b1;
    wait_empty();

    // Fill to DEPTH with wr low, stall a fifth push, then drain in order.
    wr_en = 1'b0; ra1 = 5'd3; ra2 = 5'd2;
    wlog.delete();
    for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
    @(negedge clk);
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_res_ready", 64'(res_ready), 64'(0));
    chk("fill_count", 64'(count), 64'(4));
    step();
    res_valid = 1'b1; res_rd = 5'd6; res_data = 32'h600;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_res_ready", 64'(res_ready), 64'(0));
      chk("stall_count", 64'(count), 64'(4));
    end
    step();
    wr_en = 1'b1;
    push(5'd6, 32'h600);
    wait_empty();
    chk("order_len", 64'(wlog.size()), 64'(5));
    for (int i = 0; i < 4; i++) chk("order_wa", 64'(wlog[i]), 64'(i + 1));
    chk("order_last", 64'(wlog[4]), 64'(6));

    // Reset during ISSUE with entries queued: everything discarded.
    wr_en = 1'b0;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    wr_en = 1'b1; ra1 = 5'd11; ra2 = 5'd12;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!we && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("issue_seen", 64'(we), 64'(1));
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 64'(we), 64'(0));
    chk("arst_empty", 64'(empty), 64'(1));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_full", 64'(full), 64'(0));
    chk("arst_res_ready", 64'(res_ready), 64'(1));
    chk("arst_wa", 64'(wa), 64'(0));
    chk("arst_wd", 64'(wd), 64'(0));
    chk("arst_hazard1", 64'(hazard1), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wlog.delete();
    repeat (10) @(negedge clk);
    chk("no_replay", 64'(wlog.size()), 64'(0));
    chk("post_rst_count", 64'(count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two, 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning data width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port res_valid  in  1  execute stage offers a result.
REQ-006 SHALL have port res_ready  out  1  unit accepts the offered result.
REQ-007 SHALL have port res_rd  in  5  destination register index.
REQ-008 SHALL have port res_data  in  XLEN  result value.
REQ-009 SHALL have port we  out  1  register-file write enable.
REQ-010 SHALL have port wa  out  5  register-file write address.
REQ-011 SHALL have port wd  out  XLEN  register-file write data.
REQ-012 SHALL have port wr  in  1  register-file write ready (low for one cycle after each write).
REQ-013 SHALL have ports ra1, ra2  in  5 each  decode-stage read addresses.
REQ-014 SHALL have ports hazard1, hazard2  out  1 each  read address has a pending write.
REQ-015 SHALL have ports count  out  $clog2(DEPTH)+1  occupied entries; full, empty  out  1 each.

Function
REQ-016 SHALL set res_ready = !full; handshake completes when res_valid && res_ready.
REQ-017 SHALL complete but not enqueue a handshake with res_rd == 0 (x0 writes discarded).
REQ-018 SHALL store accepted entries in FIFO order; no bypass from res_* to we in the same cycle.
REQ-019 SHALL run FSM IDLE / ISSUE / WAIT: IDLE->ISSUE when FIFO non-empty and wr == 1; ISSUE lasts exactly one cycle; ISSUE->WAIT unconditionally; WAIT->IDLE when wr == 1.
REQ-020 SHALL drive we = 1, wa/wd = head entry, and pop the head only in ISSUE; we = 0 otherwise, wa/wd hold last value.
REQ-021 SHALL yield latency: result accepted in cycle N into empty FIFO with wr high -> we high in cycle N+2 (IDLE->ISSUE transition at the N+1 edge).
REQ-022 SHALL allow push and pop in the same cycle; count unchanged; full cleared only by a pop.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count reaches DEPTH exactly when full.
REQ-024 SHALL assert hazardX combinationally when raX != 0 and raX matches any valid entry's rd or (we && wa == raX).
REQ-025 SHALL never assert hazardX for raX == 0.

Reset
REQ-026 SHALL, on reset asserted, immediately clear FIFO, count = 0, empty = 1, full = 0, res_ready = 1, we = 0, wa = 0, wd = 0, hazards = 0, FSM = IDLE, independent of clk.
REQ-027 SHALL discard any in-flight entry when reset is asserted mid-ISSUE or mid-WAIT; no write is replayed.

Configuration
REQ-028 SHALL, with WB_FORWARD_EN defined, add outputs fwd1_valid/fwd2_valid (1) and fwd1_data/fwd2_data (XLEN) carrying the youngest matching pending entry's data, and SHALL then hold hazardX = 0.
REQ-029 SHALL, without WB_FORWARD_EN, omit fwd ports and behave as REQ-024.

Structure
REQ-030 SHALL place XLEN default, register-index width (5), FSM state enum and queue-entry struct {rd, data} in shared package cpu_pkg.
REQ-031 SHALL implement the queue as sub-module wb_fifo (parameterised DEPTH, entry type); FSM and hazard compare in writeback_unit.

Verification
REQ-032 SHALL cover: push rd=5 data=0xDEADBEEF, wr=1 -> we=1, wa=5, wd=0xDEADBEEF two cycles later, one cycle wide.
REQ-033 SHALL cover: push rd=0 data=0x1234 -> res_ready stays 1, count stays 0, we never asserted.
REQ-034 SHALL cover: 5 pushes (DEPTH=4) with wr held 0 -> full=1, res_ready=0 after 4th, 5th stalls; raise wr -> 4 writes in order, one per ISSUE/WAIT cycle pair.
REQ-035 SHALL cover: entry rd=7 pending, ra1=7, ra2=0 -> hazard1=1, hazard2=0; with WB_FORWARD_EN, fwd1_valid=1, fwd1_data=entry data.
REQ-036 SHALL cover: two entries rd=3 (0x11 then 0x22) with WB_FORWARD_EN, ra1=3 -> fwd1_data=0x22.
REQ-037 SHALL cover: reset pulse during ISSUE with 3 entries queued -> we=0 asynchronously, empty=1, no writes after release.
